mul8_seq_ctrl: RTL and testbench

- Sequencing controller that computes an 8x8 unsigned product by time-multiplexing one combinational 4x4 array multiplier (`array_multiplier`, ports x, y, product) over four nibble-pair steps.
- Accumulates the shifted partial products in a 16-bit register.
- Operands enter on a valid/ready input handshake; the result leaves on a valid/ready output handshake.
- Sits between the operand source and any consumer needing 8-bit multiplies without the area of an 8x8 array.

---
 rtl/mul8_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_mul8_seq_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul8_seq_ctrl.sv
// 8x8 unsigned multiply built by sequencing one 4x4 array multiplier over four nibble pairs.
// Optional macro MUL8_SIGNED_EN adds an is_signed input for two's complement operands.

module array_multiplier (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] product
);
  assign product = {4'h0, x} * {4'h0, y};
endmodule

module mul8_seq_ctrl #(
  parameter bit EARLY_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
`ifdef MUL8_SIGNED_EN
  input  logic        is_signed,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [15:0] acc_q, acc_d;
  logic [7:0]  opa_q, opa_d, opb_q, opb_d;
  logic [7:0]  mag_a, mag_b;
  logic [3:0]  mul_x, mul_y;
  logic [7:0]  pp;
  logic [15:0] pp_ext, pp_sh;
  logic        accept, zero_op;

  assign accept  = (state_q == StIdle) && in_valid;
  assign zero_op = EARLY_ZERO && ((a == 8'h00) || (b == 8'h00));

`ifdef MUL8_SIGNED_EN
  logic neg_q, neg_d;

  // |-128| is 128, which still fits the 8-bit unsigned magnitude.
  assign mag_a = (is_signed && a[7]) ? (~a + 8'd1) : a;
  assign mag_b = (is_signed && b[7]) ? (~b + 8'd1) : b;
  assign neg_d = accept ? (is_signed & (a[7] ^ b[7])) : neg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) neg_q <= 1'b0;
    else        neg_q <= neg_d;
  end
`else
  assign mag_a = a;
  assign mag_b = b;
`endif

  assign mul_x = step_q[0] ? opa_q[7:4] : opa_q[3:0];
  assign mul_y = step_q[1] ? opb_q[7:4] : opb_q[3:0];

  array_multiplier u_array_multiplier (
    .x       (mul_x),
    .y       (mul_y),
    .product (pp)
  );

  assign pp_ext = {8'h00, pp};

  always_comb begin
    pp_sh = pp_ext;
    unique case (step_q)
      2'd0:    pp_sh = pp_ext;
      2'd1,
      2'd2:    pp_sh = pp_ext << 4;
      default: pp_sh = pp_ext << 8;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StMul;
      StMul:   if (step_q == 2'd3) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
`ifdef MUL8_SIGNED_EN
    product   = neg_q ? (~acc_q + 16'd1) : acc_q;
`else
    product   = acc_q;
`endif
  end

  // Zero bypass jumps straight to the last step: with a zero operand its partial product
  // is zero, so a single MUL cycle finishes the operation.
  always_comb begin
    step_d = step_q;
    acc_d  = acc_q;
    opa_d  = opa_q;
    opb_d  = opb_q;
    if (accept) begin
      opa_d  = mag_a;
      opb_d  = mag_b;
      acc_d  = 16'h0000;
      step_d = zero_op ? 2'd3 : 2'd0;
    end else if (state_q == StMul) begin
      acc_d  = acc_q + pp_sh;
      step_d = step_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= 2'd0;
      acc_q  <= 16'h0000;
      opa_q  <= 8'h00;
      opb_q  <= 8'h00;
    end else begin
      step_q <= step_d;
      acc_q  <= acc_d;
      opa_q  <= opa_d;
      opb_q  <= opb_d;
    end
  end

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Scoreboard bench for mul8_seq_ctrl: one instance with the zero bypass, one without.
// Expected products and due cycles are queued at acceptance and checked every cycle.

module tb_mul8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_ez, in_valid_nz;
  logic        in_ready_ez, in_ready_nz;
  logic        out_valid_ez, out_valid_nz;
  logic        busy_ez, busy_nz;
  logic [15:0] product_ez, product_nz;
  logic [7:0]  a, b;
  logic        is_s;
  logic        out_ready;
  logic        sel;  // 1: observe the EARLY_ZERO=1 instance

  always #5 clk = ~clk;

  mul8_seq_ctrl #(.EARLY_ZERO(1'b1)) dut_ez (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_ez),
    .in_ready  (in_ready_ez),
    .a         (a),
    .b         (b),
`ifdef MUL8_SIGNED_EN
    .is_signed (is_s),
`endif
    .out_valid (out_valid_ez),
    .out_ready (out_ready),
    .product   (product_ez),
    .busy      (busy_ez)
  );

  mul8_seq_ctrl #(.EARLY_ZERO(1'b0)) dut_nz (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_nz),
    .in_ready  (in_ready_nz),
    .a         (a),
    .b         (b),
`ifdef MUL8_SIGNED_EN
    .is_signed (is_s),
`endif
    .out_valid (out_valid_nz),
    .out_ready (out_ready),
    .product   (product_nz),
    .busy      (busy_nz)
  );

  logic        obs_in_valid, obs_in_ready, obs_out_valid, obs_busy;
  logic [15:0] obs_product;
  assign obs_in_valid  = sel ? in_valid_ez  : in_valid_nz;
  assign obs_in_ready  = sel ? in_ready_ez  : in_ready_nz;
  assign obs_out_valid = sel ? out_valid_ez : out_valid_nz;
  assign obs_busy      = sel ? busy_ez      : busy_nz;
  assign obs_product   = sel ? product_ez   : product_nz;

  typedef struct {
    logic [15:0] prod;
    int unsigned due;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int unsigned n_acc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y, input bit s);
    logic signed [15:0] sx, sy;
    if (s) begin
      sx = {{8{x[7]}}, x};
      sy = {{8{y[7]}}, y};
      return 16'(sx * sy);
    end
    return {8'h00, x} * {8'h00, y};
  endfunction

  // Monitor: all DUT-side comparisons happen on the falling edge.
  always @(negedge clk) begin
    bit   exp_ready, exp_valid;
    exp_t e;
    if (!rst_n) begin
      check_eq("rst_in_ready", obs_in_ready, 1);
      check_eq("rst_out_valid", obs_out_valid, 0);
      check_eq("rst_product", obs_product, 0);
      check_eq("rst_busy", obs_busy, 0);
      q.delete();
    end else begin
      exp_ready = (q.size() == 0);
      exp_valid = 1'b0;
      if (!exp_ready) exp_valid = (cyc >= q[0].due);
      check_eq("in_ready", obs_in_ready, exp_ready);
      check_eq("busy", obs_busy, !exp_ready);
      check_eq("out_valid", obs_out_valid, exp_valid);
      if (exp_valid) begin
        check_eq("product", obs_product, q[0].prod);
        if (out_ready) void'(q.pop_front());
      end else if (exp_ready && obs_in_valid) begin
        e.prod = model(a, b, is_s);
        e.due  = cyc + 1 + ((sel && (a == 8'h00 || b == 8'h00)) ? 1 : 4);
        q.push_back(e);
        n_acc++;
      end
    end
  end

  task automatic send(input logic [7:0] x, input logic [7:0] y, input bit s, input bit hold);
    int unsigned n;
    bit ok;
    a    = x;
    b    = y;
    is_s = s;
    if (sel) in_valid_ez = 1'b1;
    else     in_valid_nz = 1'b1;
    n  = n_acc;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (n_acc != n) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    if (!hold) begin
      in_valid_ez = 1'b0;
      in_valid_nz = 1'b0;
    end
    if (!ok) check_eq("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
    end
    #1;
    if (!ok) check_eq("drain_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    in_valid_ez = 1'b0;
    in_valid_nz = 1'b0;
    a           = 8'h00;
    b           = 8'h00;
    is_s        = 1'b0;
    out_ready   = 1'b1;
    sel         = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic multiply, full sequence.
    send(8'd200, 8'd150, 1'b0, 1'b0);
    drain();

    // Long backpressure on the maximum product.
    out_ready = 1'b0;
    send(8'd255, 8'd255, 1'b0, 1'b0);
    repeat (14) @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Zero operand with and without the bypass.
    send(8'd0, 8'd77, 1'b0, 1'b0);
    drain();
    sel = 1'b0;
    send(8'd0, 8'd77, 1'b0, 1'b0);
    drain();
    send(8'd9, 8'd0, 1'b0, 1'b0);
    drain();
    sel = 1'b1;

    // Back-to-back stream; the next pair sits on the inputs during MUL.
    send(8'd3, 8'd5, 1'b0, 1'b1);
    send(8'd16, 8'd16, 1'b0, 1'b1);
    send(8'd15, 8'd240, 1'b0, 1'b0);
    drain();

    // Reset in the middle of an operation.
    send(8'd100, 8'd100, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(8'd12, 8'd12, 1'b0, 1'b0);
    drain();

    // Random operands on both instances.
    for (int i = 0; i < 8; i++) begin
      sel = i[0];
      send(8'($urandom_range(0, 255)), (i == 3) ? 8'h00 : 8'($urandom_range(0, 255)),
           1'b0, 1'b0);
      drain();
    end
    sel = 1'b1;

`ifdef MUL8_SIGNED_EN
    send(8'hFD, 8'd5, 1'b1, 1'b0);
    drain();
    send(8'h80, 8'h80, 1'b1, 1'b0);
    drain();
    send(8'hFD, 8'd5, 1'b0, 1'b0);
    drain();
    send(8'h7F, 8'h81, 1'b1, 1'b0);
    drain();
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
